// File: rtl/video_link_sequencer_pkg.sv
// Shared types for the DVI output bring-up sequencer: FSM state encoding and
// the width of the lock-loss statistics counter.
package video_link_pkg;

    localparam int unsigned STATS_WIDTH = 8;

    typedef enum logic [2:0] {
        PLL_RESET = 3'd0,
        WAIT_LOCK = 3'd1,
        SETTLE    = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } link_state_e;

endpackage

// File: rtl/video_link_sequencer_bit_synchronizer.sv
// Multi-flop synchronizer that brings an asynchronous level into the clk_i
// domain; the flops clear on the synchronous reset.
module bit_synchronizer #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_in,
    output logic sync_out
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], async_in};
        end
    end

    assign sync_out = sync_q[STAGES-1];

endmodule

// File: rtl/video_link_sequencer.sv
// DVI output bring-up: PLL reset, lock wait with bounded retries, settle, RUN.
// Define VIDEO_LINK_SEQ_STATS_EN to build the lock-loss event counter.
module video_link_sequencer
    import video_link_pkg::*;
#(
    parameter int unsigned RESET_CYCLES  = 100,
    parameter int unsigned LOCK_TIMEOUT  = 100000,
    parameter int unsigned SETTLE_CYCLES = 50,
    parameter int unsigned MAX_RETRIES   = 3,
    parameter int unsigned CNT_WIDTH     = $clog2(
        (RESET_CYCLES > LOCK_TIMEOUT)
            ? ((RESET_CYCLES > SETTLE_CYCLES) ? RESET_CYCLES : SETTLE_CYCLES)
            : ((LOCK_TIMEOUT > SETTLE_CYCLES) ? LOCK_TIMEOUT : SETTLE_CYCLES)) + 1
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               pll_locked_i,
    input  logic                               restart_i,
    input  logic                               enable_i,
    output logic                               pll_rst_o,
    output logic                               datapath_rst_o,
    output logic                               output_en_o,
    output logic                               link_up_o,
    output logic                               fault_o,
    output logic [$clog2(MAX_RETRIES+1)-1:0]   retries_o,
    output logic [STATS_WIDTH-1:0]             lock_loss_count_o
);

    localparam int unsigned RW = $clog2(MAX_RETRIES + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_RST    = CNT_WIDTH'(RESET_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_LOCK   = CNT_WIDTH'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_SETTLE = CNT_WIDTH'(SETTLE_CYCLES - 1);
    localparam logic [RW-1:0]        RETRY_LAST = RW'(MAX_RETRIES - 1);
    localparam logic [RW-1:0]        RETRY_MAX  = RW'(MAX_RETRIES);

    link_state_e          state_q, state_n;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_n;
    logic [RW-1:0]        retries_q, retries_n;
    logic                 locked_s;

    bit_synchronizer #(.STAGES(2)) u_lock_sync (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .async_in (pll_locked_i),
        .sync_out (locked_s)
    );

    always_comb begin
        state_n   = state_q;
        cnt_n     = cnt_q;
        retries_n = retries_q;
        if (restart_i) begin
            state_n   = PLL_RESET;
            cnt_n     = CNT_RST;
            retries_n = '0;
        end else begin
            case (state_q)
                PLL_RESET: begin
                    if (cnt_q == '0) begin
                        state_n = WAIT_LOCK;
                        cnt_n   = CNT_LOCK;
                    end else begin
                        cnt_n = cnt_q - 1'b1;
                    end
                end
                WAIT_LOCK: begin
                    if (locked_s) begin
                        state_n = SETTLE;
                        cnt_n   = CNT_SETTLE;
                    end else if (cnt_q == '0 && retries_q == RETRY_LAST) begin
                        state_n   = FAULT;
                        retries_n = RETRY_MAX;
                    end else if (cnt_q == '0) begin
                        state_n   = PLL_RESET;
                        cnt_n     = CNT_RST;
                        retries_n = retries_q + 1'b1;
                    end else begin
                        cnt_n = cnt_q - 1'b1;
                    end
                end
                SETTLE: begin
                    // A lock drop here is a glitch, not a timeout: retry budget untouched.
                    if (!locked_s) begin
                        state_n = WAIT_LOCK;
                        cnt_n   = CNT_LOCK;
                    end else if (cnt_q == '0) begin
                        state_n   = RUN;
                        retries_n = '0;
                    end else begin
                        cnt_n = cnt_q - 1'b1;
                    end
                end
                RUN: begin
                    if (!locked_s) begin
                        state_n   = PLL_RESET;
                        cnt_n     = CNT_RST;
                        retries_n = '0;
                    end
                end
                FAULT: ;
                default: begin
                    state_n = PLL_RESET;
                    cnt_n   = CNT_RST;
                end
            endcase
        end
    end

    // Outputs decode the next state so they switch on the same edge as the state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= PLL_RESET;
            cnt_q          <= CNT_RST;
            retries_q      <= '0;
            pll_rst_o      <= 1'b1;
            datapath_rst_o <= 1'b1;
            output_en_o    <= 1'b0;
            link_up_o      <= 1'b0;
            fault_o        <= 1'b0;
        end else begin
            state_q        <= state_n;
            cnt_q          <= cnt_n;
            retries_q      <= retries_n;
            pll_rst_o      <= (state_n == PLL_RESET) || (state_n == FAULT);
            datapath_rst_o <= (state_n != RUN);
            output_en_o    <= (state_q == RUN) && (state_n == RUN) && enable_i;
            link_up_o      <= (state_n == RUN);
            fault_o        <= (state_n == FAULT);
        end
    end

    assign retries_o = retries_q;

`ifdef VIDEO_LINK_SEQ_STATS_EN
    logic                   lock_lost;
    logic [STATS_WIDTH-1:0] loss_cnt_q;

    assign lock_lost = !restart_i && (state_q == RUN) && !locked_s;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            loss_cnt_q <= '0;
        end else if (lock_lost && loss_cnt_q != '1) begin
            loss_cnt_q <= loss_cnt_q + 1'b1;
        end
    end

    assign lock_loss_count_o = loss_cnt_q;
`else
    assign lock_loss_count_o = '0;
`endif

endmodule

// File: tb/tb_video_link_sequencer.sv
// Directed scoreboard bench for video_link_sequencer with short cycle parameters;
// expected lock-loss counts follow VIDEO_LINK_SEQ_STATS_EN.
module tb_video_link_sequencer;

    logic       clk = 1'b0;
    logic       rst, pll_locked, restart, enable;
    logic       pll_rst, dp_rst, oen, link_up, fault;
    logic [1:0] retries;
    logic [7:0] llc;

    always #5 clk = ~clk;

    video_link_sequencer #(
        .RESET_CYCLES  (4),
        .LOCK_TIMEOUT  (10),
        .SETTLE_CYCLES (3),
        .MAX_RETRIES   (2)
    ) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .pll_locked_i      (pll_locked),
        .restart_i         (restart),
        .enable_i          (enable),
        .pll_rst_o         (pll_rst),
        .datapath_rst_o    (dp_rst),
        .output_en_o       (oen),
        .link_up_o         (link_up),
        .fault_o           (fault),
        .retries_o         (retries),
        .lock_loss_count_o (llc)
    );

`ifdef VIDEO_LINK_SEQ_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    typedef struct {
        string       tag;
        logic [14:0] exp;
    } exp_t;

    exp_t       sb[$];
    int         errors = 0;
    int         checks = 0;
    logic [7:0] llc_exp = 8'd0;
    logic [4:0] pat;

    // {pll_rst, datapath_rst, output_en, link_up, fault, retries, lock_loss_count}
    function automatic logic [14:0] pack(input logic pr, input logic dr, input logic oe,
                                         input logic lu, input logic f, input logic [1:0] rt);
        return {pr, dr, oe, lu, f, rt, llc_exp};
    endfunction

    function automatic logic [14:0] e_pr(input logic [1:0] rt);
        return pack(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, rt);
    endfunction

    // WAIT_LOCK and SETTLE look identical on the pins
    function automatic logic [14:0] e_wl(input logic [1:0] rt);
        return pack(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, rt);
    endfunction

    function automatic logic [14:0] e_run(input logic oe);
        return pack(1'b0, 1'b0, oe, 1'b1, 1'b0, 2'd0);
    endfunction

    function automatic logic [14:0] e_fault();
        return pack(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2);
    endfunction

    task automatic check_head();
        exp_t        e;
        logic [14:0] obs;
        e   = sb.pop_front();
        obs = {pll_rst, dp_rst, oen, link_up, fault, retries, llc};
        checks++;
        assert (obs === e.exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", e.tag, obs, e.exp);
        end
    endtask

    task automatic step(input string tag, input logic [14:0] exp);
        exp_t e;
        e.tag = tag;
        e.exp = exp;
        sb.push_back(e);
        @(posedge clk);
        #1;
        check_head();
    endtask

    initial begin
        rst = 1'b1; pll_locked = 1'b0; restart = 1'b0; enable = 1'b1;
        step("reset0", e_pr(2'd0));
        step("reset1", e_pr(2'd0));
        rst = 1'b0;

        // 1: bring-up, lock arriving mid WAIT_LOCK
        repeat (3) step("s1_pll_rst", e_pr(2'd0));
        step("s1_wait_entry", e_wl(2'd0));
        repeat (2) step("s1_wait", e_wl(2'd0));
        pll_locked = 1'b1;
        repeat (5) step("s1_sync_settle", e_wl(2'd0));
        step("s1_run_entry", e_run(1'b0));
        step("s1_run_oen", e_run(1'b1));

        // 6: enable follows with one cycle of latency in RUN
        pat = 5'b00101;
        for (int i = 0; i < 5; i++) begin
            enable = pat[i];
            step("s6_enable_follow", e_run(pat[i]));
        end
        enable = 1'b1;
        step("s6_enable_high", e_run(1'b1));

        // 4: lock loss in RUN
        pll_locked = 1'b0;
        repeat (2) step("s4_sync_delay", e_run(1'b1));
        llc_exp = STATS ? 8'd1 : 8'd0;
        step("s4_lock_loss", e_pr(2'd0));

        // 2: no lock at all -> two timeouts -> FAULT
        repeat (3) step("s2_pll_rst_a", e_pr(2'd0));
        step("s2_wait_a_entry", e_wl(2'd0));
        repeat (9) step("s2_wait_a", e_wl(2'd0));
        step("s2_timeout_a", e_pr(2'd1));
        repeat (3) step("s2_pll_rst_b", e_pr(2'd1));
        step("s2_wait_b_entry", e_wl(2'd1));
        repeat (9) step("s2_wait_b", e_wl(2'd1));
        step("s2_fault", e_fault());
        repeat (3) step("s2_fault_sticky", e_fault());
        restart = 1'b1;
        step("s2_restart", e_pr(2'd0));
        restart = 1'b0;

        // 3: one timeout, then a lock glitch during SETTLE
        repeat (3) step("s3_pll_rst", e_pr(2'd0));
        step("s3_wait_entry", e_wl(2'd0));
        repeat (9) step("s3_wait", e_wl(2'd0));
        step("s3_timeout", e_pr(2'd1));
        repeat (3) step("s3_pll_rst_b", e_pr(2'd1));
        step("s3_wait_b_entry", e_wl(2'd1));
        pll_locked = 1'b1;
        repeat (3) step("s3_to_settle", e_wl(2'd1));
        pll_locked = 1'b0;
        step("s3_glitch", e_wl(2'd1));
        pll_locked = 1'b1;
        repeat (5) step("s3_resettle", e_wl(2'd1));
        step("s3_run_entry", e_run(1'b0));
        step("s3_run_oen", e_run(1'b1));

        // 5: reset beats restart; then restart alone in WAIT_LOCK
        rst = 1'b1; restart = 1'b1; pll_locked = 1'b0;
        llc_exp = 8'd0;
        step("s5_rst_restart", e_pr(2'd0));
        rst = 1'b0; restart = 1'b0;
        repeat (3) step("s5_pll_rst", e_pr(2'd0));
        step("s5_wait_entry", e_wl(2'd0));
        repeat (9) step("s5_wait", e_wl(2'd0));
        step("s5_timeout", e_pr(2'd1));
        repeat (3) step("s5_pll_rst_b", e_pr(2'd1));
        step("s5_wait_b_entry", e_wl(2'd1));
        repeat (2) step("s5_wait_b", e_wl(2'd1));
        restart = 1'b1;
        step("s5_restart", e_pr(2'd0));
        restart = 1'b0;
        repeat (3) step("s5_reload", e_pr(2'd0));
        step("s5_reload_done", e_wl(2'd0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
